// File: rtl/pipe_pkg.sv
// Shared types for the pipeline controller and the hazard detector:
// stall codes, strobe bundle and the stall-code decoder.
package pipe_pkg;

  typedef enum logic [1:0] {
    STALL_NONE    = 2'b00,
    STALL_DATA    = 2'b01,
    STALL_CTRL    = 2'b10,
    STALL_DATA_IF = 2'b11
  } stall_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_flush;
  } strobe_t;

  localparam strobe_t STROBE_RUN     = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0};
  localparam strobe_t STROBE_DATA    = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b1};
  localparam strobe_t STROBE_CTRL    = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1};
  localparam strobe_t STROBE_DATA_IF = '{pc_en: 1'b0, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b0};
  localparam strobe_t STROBE_RESET   = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1, id_ex_flush: 1'b1};

  function automatic strobe_t decode_stall(input stall_e code);
    strobe_t s;
    s = STROBE_RUN;
    case (code)
      STALL_NONE:    s = STROBE_RUN;
      STALL_DATA:    s = STROBE_DATA;
      STALL_CTRL:    s = STROBE_CTRL;
      STALL_DATA_IF: s = STROBE_DATA_IF;
      default:       s = STROBE_RUN;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/perf_cnt.sv
// Wrapping performance counter; a clear beats an increment in the same cycle.
module perf_cnt #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i) begin
      cnt_o <= cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: decodes hazard stall codes into PC / IF-ID / ID-EX
// strobes, tracks per-stage valid bits and keeps the performance counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           stall_i,
  input  logic                 cnt_clr_i,
  output logic                 pc_en_o,
  output logic                 if_id_en_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_flush_o,
  output logic                 id_vld_o,
  output logic                 ex_vld_o,
  output logic                 mem_vld_o,
  output logic                 wb_vld_o,
  output logic                 retire_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o,
  output logic [CNT_WIDTH-1:0] instret_cnt_o,
  output logic [CNT_WIDTH-1:0] dstall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  stall_e  code;
  strobe_t strb;
  logic    id_q, ex_q, mem_q, wb_q;
  logic    dstall_inc, flush_inc;

  assign code = stall_e'(stall_i);

  // Reset forces a frozen PC and bubbles into both pipeline registers.
  always_comb begin
    strb = decode_stall(code);
    if (rst_i) begin
      strb = STROBE_RESET;
    end
  end

  assign pc_en_o       = strb.pc_en;
  assign if_id_en_o    = strb.if_id_en;
  assign if_id_flush_o = strb.if_id_flush;
  assign id_ex_flush_o = strb.id_ex_flush;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q  <= 1'b0;
      ex_q  <= 1'b0;
      mem_q <= 1'b0;
      wb_q  <= 1'b0;
    end else begin
      id_q  <= strb.if_id_flush ? 1'b0 : (strb.if_id_en ? 1'b1 : id_q);
      ex_q  <= strb.id_ex_flush ? 1'b0 : id_q;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign id_vld_o  = id_q;
  assign ex_vld_o  = ex_q;
  assign mem_vld_o = mem_q;
  assign wb_vld_o  = wb_q;
  assign retire_o  = wb_q;

  assign dstall_inc = (code == STALL_DATA) || (code == STALL_DATA_IF);
  assign flush_inc  = (code == STALL_CTRL);

  perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(1'b1), .clr_i(cnt_clr_i), .cnt_o(cycle_cnt_o)
  );

  perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_instret_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(wb_q), .clr_i(cnt_clr_i), .cnt_o(instret_cnt_o)
  );

  perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_dstall_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(dstall_inc), .clr_i(cnt_clr_i), .cnt_o(dstall_cnt_o)
  );

  perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(flush_inc), .clr_i(cnt_clr_i), .cnt_o(flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle scoreboard plus scenario tasks.
module tb_pipe_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  stall_i = 2'b00;
  logic        cnt_clr_i = 1'b0;

  logic        pc_en_o, if_id_en_o, if_id_flush_o, id_ex_flush_o;
  logic        id_vld_o, ex_vld_o, mem_vld_o, wb_vld_o, retire_o;
  logic [31:0] cycle_cnt_o, instret_cnt_o, dstall_cnt_o, flush_cnt_o;

  logic        n_pc_en, n_if_id_en, n_if_id_flush, n_id_ex_flush;
  logic        n_id_vld, n_ex_vld, n_mem_vld, n_wb_vld, n_retire;
  logic [3:0]  n_cycle_cnt, n_instret_cnt, n_dstall_cnt, n_flush_cnt;

  pipe_ctrl #(.CNT_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .cnt_clr_i(cnt_clr_i),
    .pc_en_o(pc_en_o), .if_id_en_o(if_id_en_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_flush_o(id_ex_flush_o), .id_vld_o(id_vld_o), .ex_vld_o(ex_vld_o),
    .mem_vld_o(mem_vld_o), .wb_vld_o(wb_vld_o), .retire_o(retire_o),
    .cycle_cnt_o(cycle_cnt_o), .instret_cnt_o(instret_cnt_o),
    .dstall_cnt_o(dstall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  pipe_ctrl #(.CNT_WIDTH(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .cnt_clr_i(cnt_clr_i),
    .pc_en_o(n_pc_en), .if_id_en_o(n_if_id_en), .if_id_flush_o(n_if_id_flush),
    .id_ex_flush_o(n_id_ex_flush), .id_vld_o(n_id_vld), .ex_vld_o(n_ex_vld),
    .mem_vld_o(n_mem_vld), .wb_vld_o(n_wb_vld), .retire_o(n_retire),
    .cycle_cnt_o(n_cycle_cnt), .instret_cnt_o(n_instret_cnt),
    .dstall_cnt_o(n_dstall_cnt), .flush_cnt_o(n_flush_cnt)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  strb;
    logic [3:0]  vld;
    logic [31:0] cyc, ins, ds, fl;
    logic [3:0]  cyc4;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  logic        m_id, m_ex, m_mem, m_wb;
  logic [31:0] m_cyc, m_ins, m_ds, m_fl;
  logic [3:0]  m_cyc4;

  task automatic model_reset();
    {m_id, m_ex, m_mem, m_wb} = 4'b0000;
    m_cyc = 0; m_ins = 0; m_ds = 0; m_fl = 0; m_cyc4 = 0;
  endtask

  // Drive one cycle (entered ~3ns after a rising edge), predict the strobes for
  // this cycle and the state after the coming edge, queue the prediction.
  task automatic cyc(input logic [1:0] code, input logic clr, input logic rst);
    exp_t e;
    stall_i = code; cnt_clr_i = clr; rst_i = rst;
    if (rst) begin
      e.strb = 4'b0011;
      model_reset();
    end else begin
      case (code)
        2'b00:   e.strb = 4'b1100;
        2'b01:   e.strb = 4'b0001;
        2'b10:   e.strb = 4'b1111;
        default: e.strb = 4'b0110;
      endcase
      if (clr) begin
        m_cyc = 0; m_ins = 0; m_ds = 0; m_fl = 0; m_cyc4 = 0;
      end else begin
        m_cyc  = m_cyc + 1;
        m_cyc4 = m_cyc4 + 4'd1;
        m_ins  = m_ins + 32'(m_wb);
        m_ds   = m_ds + 32'((code == 2'b01) || (code == 2'b11));
        m_fl   = m_fl + 32'(code == 2'b10);
      end
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = e.strb[0] ? 1'b0 : m_id;
      m_id  = e.strb[1] ? 1'b0 : (e.strb[2] ? 1'b1 : m_id);
    end
    e.vld = {m_id, m_ex, m_mem, m_wb};
    e.cyc = m_cyc; e.ins = m_ins; e.ds = m_ds; e.fl = m_fl; e.cyc4 = m_cyc4;
    sb_q.push_back(e);
    @(posedge clk_i);
    #3;
  endtask

  // Strobes are combinational: compare mid-cycle against the pending entry.
  always @(negedge clk_i) begin
    if (sb_q.size() > 0) begin
      checks++;
      if ({pc_en_o, if_id_en_o, if_id_flush_o, id_ex_flush_o} !== sb_q[0].strb) begin
        failures++;
        $display("FAIL sb_strobes t=%0t got=%b exp=%b stall=%b rst=%b", $time,
                 {pc_en_o, if_id_en_o, if_id_flush_o, id_ex_flush_o}, sb_q[0].strb, stall_i, rst_i);
      end
    end
  end

  always @(posedge clk_i) begin : sb_post
    exp_t e;
    #2;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({id_vld_o, ex_vld_o, mem_vld_o, wb_vld_o} !== e.vld) begin
        failures++;
        $display("FAIL sb_valid t=%0t got=%b exp=%b", $time, {id_vld_o, ex_vld_o, mem_vld_o, wb_vld_o}, e.vld);
      end
      checks++;
      if (retire_o !== e.vld[0]) begin
        failures++;
        $display("FAIL sb_retire t=%0t got=%b exp=%b", $time, retire_o, e.vld[0]);
      end
      checks++;
      if ({cycle_cnt_o, instret_cnt_o, dstall_cnt_o, flush_cnt_o} !== {e.cyc, e.ins, e.ds, e.fl}) begin
        failures++;
        $display("FAIL sb_counters t=%0t got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", $time,
                 cycle_cnt_o, instret_cnt_o, dstall_cnt_o, flush_cnt_o, e.cyc, e.ins, e.ds, e.fl);
      end
      checks++;
      if (n_cycle_cnt !== e.cyc4) begin
        failures++;
        $display("FAIL sb_cycle4 t=%0t got=%0d exp=%0d", $time, n_cycle_cnt, e.cyc4);
      end
    end
  end

  task automatic test_reset();
    checks++;
    if ({id_vld_o, ex_vld_o, mem_vld_o, wb_vld_o, retire_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=00000", {id_vld_o, ex_vld_o, mem_vld_o, wb_vld_o, retire_o});
    end
    checks++;
    if ({cycle_cnt_o, instret_cnt_o, dstall_cnt_o, flush_cnt_o} !== 128'd0) begin
      failures++;
      $display("FAIL reset_counters got=%0d/%0d/%0d/%0d exp=0", cycle_cnt_o, instret_cnt_o, dstall_cnt_o, flush_cnt_o);
    end
    stall_i = 2'b00;
    #1;
    checks++;
    if ({pc_en_o, if_id_en_o, if_id_flush_o, id_ex_flush_o} !== 4'b0011) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=0011", {pc_en_o, if_id_en_o, if_id_flush_o, id_ex_flush_o});
    end
    cyc(2'b10, 1'b0, 1'b1);
    cyc(2'b11, 1'b0, 1'b1);
    cyc(2'b01, 1'b0, 1'b1);
  endtask

  task automatic test_fill();
    int retires = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(2'b00, 1'b0, 1'b0);
      retires += int'(retire_o);
      if (i == 0) begin
        checks++;
        if ({id_vld_o, ex_vld_o} !== 2'b10) begin
          failures++;
          $display("FAIL fill_first_edge got=%b exp=10", {id_vld_o, ex_vld_o});
        end
      end
      if (i == 3) begin
        checks++;
        if (retire_o !== 1'b1) begin
          failures++;
          $display("FAIL fill_wb_at_4 got=%b exp=1", retire_o);
        end
      end
    end
    checks++;
    if (cycle_cnt_o !== 32'd8 || retires != 5) begin
      failures++;
      $display("FAIL fill_counts cycle=%0d exp=8 retires=%0d exp=5", cycle_cnt_o, retires);
    end
    cyc(2'b00, 1'b0, 1'b0);
    checks++;
    if (instret_cnt_o !== 32'd5) begin
      failures++;
      $display("FAIL fill_instret got=%0d exp=5", instret_cnt_o);
    end
  endtask

  task automatic test_data_stall();
    logic [31:0] ds0 = dstall_cnt_o;
    int zeros = 0, first = -1;
    for (int i = 0; i < 7; i++) begin
      cyc((i < 3) ? 2'b01 : 2'b00, 1'b0, 1'b0);
      if (i < 3) begin
        checks++;
        if ({id_vld_o, ex_vld_o} !== 2'b10) begin
          failures++;
          $display("FAIL dstall_bubble i=%0d got=%b exp=10", i, {id_vld_o, ex_vld_o});
        end
      end
      if (!retire_o) begin
        zeros++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (dstall_cnt_o - ds0 !== 32'd3) begin
      failures++;
      $display("FAIL dstall_count got=%0d exp=3", dstall_cnt_o - ds0);
    end
    checks++;
    if (zeros != 3 || first != 2) begin
      failures++;
      $display("FAIL dstall_retire_gap zeros=%0d exp=3 first=%0d exp=2", zeros, first);
    end
  endtask

  task automatic test_ctrl_flush();
    logic [31:0] fl0 = flush_cnt_o;
    int zeros = 0, first = -1;
    for (int i = 0; i < 6; i++) begin
      cyc((i == 0) ? 2'b10 : 2'b00, 1'b0, 1'b0);
      if (i == 0) begin
        checks++;
        if ({id_vld_o, ex_vld_o} !== 2'b00) begin
          failures++;
          $display("FAIL ctrl_flush_valid got=%b exp=00", {id_vld_o, ex_vld_o});
        end
      end
      if (!retire_o) begin
        zeros++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (flush_cnt_o - fl0 !== 32'd1) begin
      failures++;
      $display("FAIL ctrl_flush_count got=%0d exp=1", flush_cnt_o - fl0);
    end
    checks++;
    if (zeros != 2 || first != 2) begin
      failures++;
      $display("FAIL ctrl_retire_gap zeros=%0d exp=2 first=%0d exp=2", zeros, first);
    end
  endtask

  task automatic test_data_if();
    logic [31:0] ds0 = dstall_cnt_o;
    cyc(2'b11, 1'b0, 1'b0);
    checks++;
    if ({id_vld_o, ex_vld_o} !== 2'b01) begin
      failures++;
      $display("FAIL dif_first_edge got=%b exp=01", {id_vld_o, ex_vld_o});
    end
    cyc(2'b11, 1'b0, 1'b0);
    checks++;
    if ({id_vld_o, ex_vld_o} !== 2'b00) begin
      failures++;
      $display("FAIL dif_second_edge got=%b exp=00", {id_vld_o, ex_vld_o});
    end
    checks++;
    if (dstall_cnt_o - ds0 !== 32'd2) begin
      failures++;
      $display("FAIL dif_count got=%0d exp=2", dstall_cnt_o - ds0);
    end
    for (int i = 0; i < 4; i++) cyc(2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_ctrl_after_data();
    cyc(2'b01, 1'b0, 1'b0);
    cyc(2'b10, 1'b0, 1'b0);
    checks++;
    if ({id_vld_o, ex_vld_o} !== 2'b00) begin
      failures++;
      $display("FAIL data_then_ctrl got=%b exp=00", {id_vld_o, ex_vld_o});
    end
    for (int i = 0; i < 4; i++) cyc(2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_clear();
    cyc(2'b01, 1'b1, 1'b0);
    checks++;
    if ({cycle_cnt_o, instret_cnt_o, dstall_cnt_o, flush_cnt_o} !== 128'd0 || n_cycle_cnt !== 4'd0) begin
      failures++;
      $display("FAIL clear_priority got=%0d/%0d/%0d/%0d c4=%0d exp=0", cycle_cnt_o, instret_cnt_o,
               dstall_cnt_o, flush_cnt_o, n_cycle_cnt);
    end
    cyc(2'b00, 1'b0, 1'b0);
    checks++;
    if (cycle_cnt_o !== 32'd1) begin
      failures++;
      $display("FAIL clear_resume got=%0d exp=1", cycle_cnt_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      cyc(2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0), 1'b0);
    end
    for (int i = 0; i < 4; i++) cyc(2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset_and_wrap();
    int early = 0;
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({id_vld_o, ex_vld_o, mem_vld_o, wb_vld_o, retire_o} !== 5'b0) begin
      failures++;
      $display("FAIL async_valid got=%b exp=00000", {id_vld_o, ex_vld_o, mem_vld_o, wb_vld_o, retire_o});
    end
    checks++;
    if ({cycle_cnt_o, instret_cnt_o, dstall_cnt_o, flush_cnt_o} !== 128'd0 || n_cycle_cnt !== 4'd0) begin
      failures++;
      $display("FAIL async_counters got=%0d/%0d/%0d/%0d c4=%0d exp=0", cycle_cnt_o, instret_cnt_o,
               dstall_cnt_o, flush_cnt_o, n_cycle_cnt);
    end
    model_reset();
    @(posedge clk_i);
    #3;
    cyc(2'b00, 1'b0, 1'b1);
    cyc(2'b00, 1'b0, 1'b1);
    rst_i = 1'b0;
    #1;
    early += int'(retire_o);
    for (int i = 0; i < 17; i++) begin
      cyc(2'b00, 1'b0, 1'b0);
      if (i < 3) early += int'(retire_o);
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL async_no_retire got=%0d pulses exp=0", early);
    end
    checks++;
    if (n_cycle_cnt !== 4'd1 || cycle_cnt_o !== 32'd17) begin
      failures++;
      $display("FAIL wrap_cycle4 got=%0d exp=1 cycle32=%0d exp=17", n_cycle_cnt, cycle_cnt_o);
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk_i);
    #3;
    test_reset();
    test_fill();
    test_data_stall();
    test_ctrl_flush();
    test_data_if();
    test_ctrl_after_data();
    test_clear();
    test_random();
    test_async_reset_and_wrap();
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
